alu_op_sequencer: RTL

- Upstream control stage for the 4-bit accumulator ALU.
- Accepts one operation per valid/ready handshake (op code plus operands A and B).
- Drives the ALU control pins (tin, pin, uacc, inmode, outmode, cmode) through a fixed load/execute sequence.
- Captures the ALU bus result and flags, then presents them downstream on a valid/ready result port.
- Supports chained operations that reuse the accumulator contents instead of reloading A.

---
 rtl/alu_op_sequencer_pkg.sv | 34 +++
 rtl/alu_op_sequencer_if.sv | 59 +++++
 rtl/alu_op_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_op_sequencer_pkg                                       |
// | Description : Shared encodings for the ALU operation sequencer:          |
// |               ALU function codes, accumulator/bus source selects and     |
// |               the sequencer FSM state encoding.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package alu_op_sequencer_pkg;

    // ALU function select
    localparam logic [1:0] CMODE_ADD = 2'b00;
    localparam logic [1:0] CMODE_AND = 2'b01;
    localparam logic [1:0] CMODE_OR  = 2'b10;
    localparam logic [1:0] CMODE_XOR = 2'b11;

    // Accumulator source select
    localparam logic INMODE_PIN  = 1'b1;
    localparam logic INMODE_ALU  = 1'b0;

    // Bus source select
    localparam logic OUTMODE_BUS = 1'b0;
    localparam logic OUTMODE_ALU = 1'b1;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_op_sequencer_if                                        |
// | Description : Bundles the operation request port, the ALU control/     |
// |               status pins and the result port of the sequencer.          |
// |   master : sequencer side (accepts ops, drives ALU pins, sends result)   |
// |   slave  : environment side (issues ops, models ALU, takes result)       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface alu_op_sequencer_if #(
    parameter int DW = 4,
    parameter int FW = 3
);
    import alu_op_sequencer_pkg::*;

    // Operation request
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    op_cmode;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          op_chain;

    // ALU control and status
    logic [DW-1:0] tin;
    logic [DW-1:0] pin;
    logic          uacc;
    logic          inmode;
    logic          outmode;
    logic [1:0]    cmode;
    logic [DW-1:0] alu_bus;
    logic [FW-1:0] alu_flgs;

    // Result
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [FW-1:0] res_flags;

    modport master (
        input  op_valid, op_cmode, op_a, op_b, op_chain,
        output op_ready,
        output tin, pin, uacc, inmode, outmode, cmode,
        input  alu_bus, alu_flgs,
        output res_valid, res_data, res_flags,
        input  res_ready
    );

    modport slave (
        output op_valid, op_cmode, op_a, op_b, op_chain,
        input  op_ready,
        input  tin, pin, uacc, inmode, outmode, cmode,
        output alu_bus, alu_flgs,
        input  res_valid, res_data, res_flags,
        output res_ready
    );

endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_op_sequencer                                           |
// | Description : Upstream control stage for the 4-bit accumulator ALU.      |
// |               Accepts one op per handshake, sequences LOAD/EXEC on the   |
// |               ALU pins, captures bus result + flags and offers them on   |
// |               a valid/ready result port. Chained ops reuse the           |
// |               accumulator and skip LOAD.                                 |
// | Ports       : clk, rst (sync, active-high)                               |
// |               bus      - alu_op_sequencer_if.master (op/ALU/result)      |
// |               op_count - completed-result counter, saturating at 255,   |
// |                          present only with ALU_OP_SEQUENCER_OPCNT_EN     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DW = 4,
    parameter int FW = 3
) (
    input  wire logic                clk,
    input  wire logic                rst,
`ifdef ALU_OP_SEQUENCER_OPCNT_EN
    output logic [7:0]               op_count,
`endif
    alu_op_sequencer_if.master       bus
);

    state_t        r_state;
    state_t        w_next;

    logic [1:0]    r_op_cmode;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic          r_acc_valid;

    // Last values driven on the ALU data pins; shown outside LOAD/EXEC
    logic [DW-1:0] r_pin_hold;
    logic [DW-1:0] r_tin_hold;
    logic [1:0]    r_cmode_hold;

    logic [DW-1:0] r_res_data;
    logic [FW-1:0] r_res_flags;

    logic          w_accept;
    logic          w_eff_chain;
    logic          w_res_hs;

    assign w_accept    = (r_state == ST_IDLE) && bus.op_valid;
    // A chain request is only honoured once the accumulator holds a result
    assign w_eff_chain = bus.op_chain && r_acc_valid;
    assign w_res_hs    = (r_state == ST_RESP) && bus.res_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bus.op_ready  = 1'b0;
        bus.uacc      = 1'b0;
        bus.inmode    = INMODE_PIN;
        bus.outmode   = OUTMODE_BUS;
        bus.res_valid = 1'b0;
        bus.pin       = r_pin_hold;
        bus.tin       = r_tin_hold;
        bus.cmode     = r_cmode_hold;
        case (r_state)
            ST_IDLE: begin
                bus.op_ready = 1'b1;
                if (w_accept) w_next = w_eff_chain ? ST_EXEC : ST_LOAD;
            end
            ST_LOAD: begin
                bus.pin  = r_a;
                bus.uacc = 1'b1;
                w_next   = ST_EXEC;
            end
            ST_EXEC: begin
                bus.tin     = r_b;
                bus.cmode   = r_op_cmode;
                bus.inmode  = INMODE_ALU;
                bus.outmode = OUTMODE_ALU;
                bus.uacc    = 1'b1;
                w_next      = ST_RESP;
            end
            ST_RESP: begin
                bus.res_valid = 1'b1;
                if (w_res_hs) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_cmode   <= CMODE_ADD;
            r_a          <= '0;
            r_b          <= '0;
            r_acc_valid  <= 1'b0;
            r_pin_hold   <= '0;
            r_tin_hold   <= '0;
            r_cmode_hold <= CMODE_ADD;
            r_res_data   <= '0;
            r_res_flags  <= '0;
        end else begin
            if (w_accept) begin
                r_op_cmode <= bus.op_cmode;
                r_a        <= bus.op_a;
                r_b        <= bus.op_b;
            end
            if (r_state == ST_LOAD) r_pin_hold <= r_a;
            if (r_state == ST_EXEC) begin
                r_tin_hold   <= r_b;
                r_cmode_hold <= r_op_cmode;
                r_res_data   <= bus.alu_bus;
                r_res_flags  <= bus.alu_flgs;
                r_acc_valid  <= 1'b1;
            end
        end
    end

    assign bus.res_data  = r_res_data;
    assign bus.res_flags = r_res_flags;

`ifdef ALU_OP_SEQUENCER_OPCNT_EN
    logic [7:0] r_op_count;

    always_ff @(posedge clk) begin
        if (rst)                               r_op_count <= 8'd0;
        else if (w_res_hs && r_op_count != 8'hFF) r_op_count <= r_op_count + 8'd1;
    end

    assign op_count = r_op_count;
`endif

endmodule
`default_nettype wire
